// File: rtl/ga_raster_irq.sv
// Raster interrupt generator in the style of the CPC gate array.
// A line divider raises INT every LINE_DIV HSYNC ends. VSYNC resynchronises
// the divider VS_DELAY lines later. An optional raster-line compare (PRI mode)
// replaces the divider as the interrupt source while its register is nonzero.
module ga_raster_irq #(
    parameter int LINE_DIV = 52,
    parameter int CNT_W    = 6,
    parameter int VS_DELAY = 2,
    parameter int PRI_W    = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CE,
    input  logic             HSYNC_IN,
    input  logic             VSYNC_IN,
    input  logic             INTACK,
    input  logic             WE,
    input  logic [7:0]       D,
    input  logic             PRI_WE,
    input  logic [PRI_W-1:0] PRI_D,
    output logic             INT,
    output logic             INT_SRC,
    output logic [CNT_W-1:0] LINE_CNT
);

    localparam int               DLY_W    = 4;
    localparam logic [CNT_W-1:0] DIV_TOP  = CNT_W'(LINE_DIV - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(VS_DELAY);
    localparam logic [PRI_W-1:0] RAS_MAX  = {PRI_W{1'b1}};
    localparam logic [PRI_W-1:0] PRI_OFF  = {PRI_W{1'b0}};

    // Gate-array control write: function 2'b10 with the interrupt-reset bit set.
    function automatic logic is_int_reset(input logic [1:0] fn, input logic rst_bit);
        return (fn == 2'b10) && rst_bit;
    endfunction

    logic             hs_r;
    logic             vs_r;
    logic             smp_vld_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DLY_W-1:0] dly_r;
    logic [PRI_W-1:0] ras_r;
    logic [PRI_W-1:0] pri_r;
    logic             int_r;
    logic             src_r;

    logic             h_ev_s;
    logic             v_ev_s;
    logic             pri_on_s;
    logic             resync_s;
    logic             we_clr_s;
    logic [PRI_W-1:0] ras_inc_s;
    logic [CNT_W-1:0] cnt_n_s;
    logic [DLY_W-1:0] dly_n_s;
    logic [PRI_W-1:0] ras_n_s;
    logic [PRI_W-1:0] pri_n_s;
    logic             int_n_s;
    logic             src_n_s;

    // Remaining data bits select other gate-array functions, not handled here.
    logic             d_unused_s;
    assign d_unused_s = ^{D[5], D[3:0]};

    // Event detection and next-state for all counters and the interrupt flag.
    always_comb begin
        h_ev_s    = CE & smp_vld_r & hs_r & ~HSYNC_IN;
        v_ev_s    = CE & smp_vld_r & ~vs_r & VSYNC_IN;
        pri_on_s  = (pri_r != PRI_OFF);
        we_clr_s  = WE & is_int_reset(D[7:6], D[4]);
        ras_inc_s = (ras_r == RAS_MAX) ? ras_r : ras_r + PRI_W'(1);
        resync_s  = 1'b0;
        cnt_n_s   = cnt_r;
        dly_n_s   = dly_r;
        ras_n_s   = ras_r;
        int_n_s   = int_r;
        src_n_s   = src_r;
        pri_n_s   = PRI_WE ? PRI_D : pri_r;

        // A VSYNC rise restarts the delay even when it lands on an HSYNC end,
        // and that coincident HSYNC end is not counted as a delay step.
        if (v_ev_s) begin
            dly_n_s = DLY_LOAD;
        end else if (h_ev_s && (dly_r != 4'd0)) begin
            dly_n_s  = dly_r - 4'd1;
            resync_s = (dly_r == 4'd1);
        end else begin
            dly_n_s = dly_r;
        end

        if (h_ev_s) begin
            if (resync_s) begin
                // Resync wins over the divider wrap on the same line.
                cnt_n_s = {CNT_W{1'b0}};
                ras_n_s = PRI_OFF;
                if (cnt_r[CNT_W-1] && !pri_on_s) begin
                    int_n_s = 1'b1;
                    src_n_s = 1'b0;
                end else begin
                    int_n_s = int_r;
                end
            end else begin
                ras_n_s = ras_inc_s;
                if (cnt_r == DIV_TOP) begin
                    cnt_n_s = {CNT_W{1'b0}};
                    if (!pri_on_s) begin
                        int_n_s = 1'b1;
                        src_n_s = 1'b0;
                    end else begin
                        int_n_s = int_r;
                    end
                end else begin
                    cnt_n_s = cnt_r + CNT_W'(1);
                end
                // Compare uses the register value held before any same-cycle write.
                if (pri_on_s && (ras_inc_s == pri_r)) begin
                    int_n_s = 1'b1;
                    src_n_s = 1'b1;
                end else begin
                    src_n_s = src_n_s;
                end
            end
        end else begin
            cnt_n_s = cnt_r;
        end

        // Acknowledge drops INT; only a divider interrupt disarms the guard bit.
        if (INTACK) begin
            int_n_s = 1'b0;
            if (!src_r) begin
                cnt_n_s[CNT_W-1] = 1'b0;
            end else begin
                cnt_n_s = cnt_n_s;
            end
        end else begin
            int_n_s = int_n_s;
        end

        // Software interrupt reset has the final word on INT and the divider.
        if (we_clr_s) begin
            int_n_s = 1'b0;
            cnt_n_s = {CNT_W{1'b0}};
        end else begin
            int_n_s = int_n_s;
        end
    end

    // State register; reset clears everything including the sample-valid flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            smp_vld_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            dly_r     <= 4'd0;
            ras_r     <= PRI_OFF;
            pri_r     <= PRI_OFF;
            int_r     <= 1'b0;
            src_r     <= 1'b0;
        end else begin
            if (CE) begin
                hs_r      <= HSYNC_IN;
                vs_r      <= VSYNC_IN;
                smp_vld_r <= 1'b1;
            end else begin
                hs_r      <= hs_r;
                vs_r      <= vs_r;
                smp_vld_r <= smp_vld_r;
            end
            cnt_r <= cnt_n_s;
            dly_r <= dly_n_s;
            ras_r <= ras_n_s;
            pri_r <= pri_n_s;
            int_r <= int_n_s;
            src_r <= src_n_s;
        end
    end

    assign INT      = int_r;
    assign INT_SRC  = src_r;
    assign LINE_CNT = cnt_r;

endmodule

// File: tb/tb_ga_raster_irq.sv
// Directed bench for ga_raster_irq: one default-parameter instance and one
// small instance (13/4/3). Expected {INT, INT_SRC, LINE_CNT} values go into
// a scoreboard queue as stimulus is applied and are popped at each check.
module tb_ga_raster_irq;

    logic       clk = 1'b0;
    logic       rst1_n, rst2_n;
    logic       ce, hsync, vsync, intack, we, pri_we;
    logic [7:0] d, pri_d;
    logic       int1, src1, int2, src2;
    logic [5:0] cnt1;
    logic [3:0] cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    ga_raster_irq u_dut1 (
        .CLK(clk), .RESET_N(rst1_n), .CE(ce), .HSYNC_IN(hsync), .VSYNC_IN(vsync),
        .INTACK(intack), .WE(we), .D(d), .PRI_WE(pri_we), .PRI_D(pri_d),
        .INT(int1), .INT_SRC(src1), .LINE_CNT(cnt1)
    );

    ga_raster_irq #(.LINE_DIV(13), .CNT_W(4), .VS_DELAY(3), .PRI_W(8)) u_dut2 (
        .CLK(clk), .RESET_N(rst2_n), .CE(ce), .HSYNC_IN(hsync), .VSYNC_IN(vsync),
        .INTACK(intack), .WE(we), .D(d), .PRI_WE(pri_we), .PRI_D(pri_d),
        .INT(int2), .INT_SRC(src2), .LINE_CNT(cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int i, input int s, input int c);
        return 32'(i * 512 + s * 256 + c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hpulse(input int n);
        for (int k = 0; k < n; k++) begin
            hsync = 1'b1;
            tick();
            hsync = 1'b0;
            tick();
        end
    endtask

    task automatic vpulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic ack();
        intack = 1'b1;
        tick();
        intack = 1'b0;
    endtask

    task automatic ga_write(input logic [7:0] v);
        we = 1'b1;
        d  = v;
        tick();
        we = 1'b0;
        d  = 8'h00;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed int/src/cnt=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk1();
        check_obs({22'd0, int1, src1, 2'b00, cnt1});
    endtask

    task automatic chk2();
        check_obs({22'd0, int2, src2, 4'b0000, cnt2});
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0;
        ce = 1'b1; hsync = 1'b0; vsync = 1'b0; intack = 1'b0;
        we = 1'b0; d = 8'h00; pri_we = 1'b0; pri_d = 8'h00;
        repeat (3) tick();
        push("reset1", mk(0, 0, 0)); chk1();
        push("reset2", mk(0, 0, 0)); chk2();

        // First CE after reset must not see VSYNC high as a rise.
        vsync = 1'b1;
        rst1_n = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        push("first_ce_no_vevent", mk(0, 0, 2));
        hpulse(2); chk1();

        // HSYNC activity while CE is low is ignored.
        push("ce_gating", mk(0, 0, 2));
        ce = 1'b0; hpulse(3); ce = 1'b1; tick(); chk1();

        // Only function 10 with bit 4 set clears.
        push("we_no_bit4", mk(0, 0, 2));
        ga_write(8'h80); chk1();
        push("we_other_fn", mk(0, 0, 2));
        ga_write(8'hD0); chk1();
        push("we_clear", mk(0, 0, 0));
        ga_write(8'h90); chk1();

        // 52 lines -> divider interrupt, then acknowledge.
        push("div_51", mk(0, 0, 51));
        hpulse(51); chk1();
        push("div_int_52", mk(1, 0, 0));
        hpulse(1); chk1();
        push("intack_clear", mk(0, 0, 0));
        ack(); chk1();

        // Acknowledge at 40 strips the guard bit -> 8, next INT 44 lines later.
        push("cnt_40", mk(0, 0, 40));
        hpulse(40); chk1();
        push("ack_at_40", mk(0, 0, 8));
        ack(); chk1();
        push("after_43", mk(0, 0, 51));
        hpulse(43); chk1();
        push("int_after_44", mk(1, 0, 0));
        hpulse(1); chk1();
        ack();

        // VSYNC resync with guard bit set -> INT on 2nd line.
        hpulse(40);
        vpulse();
        push("vs_line1", mk(0, 0, 41));
        hpulse(1); chk1();
        push("vs_resync_int", mk(1, 0, 0));
        hpulse(1); chk1();
        ack();

        // VSYNC resync with guard bit clear -> no INT.
        hpulse(10);
        vpulse();
        hpulse(2);
        push("vs_resync_noint", mk(0, 0, 0)); chk1();

        // VSYNC rise on an HSYNC end reloads; that line is not a delay step.
        hpulse(40);
        hsync = 1'b1; tick();
        hsync = 1'b0; vsync = 1'b1; tick();
        vsync = 1'b0;
        push("coincident_v_h", mk(0, 0, 42));
        hpulse(1); chk1();
        push("coincident_resync", mk(1, 0, 0));
        hpulse(1); chk1();
        ack();

        // Terminal line + INTACK + WE clear in the same cycle.
        hpulse(51);
        hsync = 1'b1; tick();
        hsync = 1'b0; intack = 1'b1; we = 1'b1; d = 8'h90; tick();
        intack = 1'b0; we = 1'b0; d = 8'h00;
        push("term_ack_we", mk(0, 0, 0)); chk1();

        // Terminal line + INTACK only: INT must end up 0.
        hpulse(51);
        hsync = 1'b1; tick();
        hsync = 1'b0; intack = 1'b1; tick();
        intack = 1'b0;
        push("term_ack", mk(0, 0, 0)); chk1();

        // PRI mode: compare at line 100 after resync, divider INTs suppressed.
        pri_we = 1'b1; pri_d = 8'd100; tick();
        pri_we = 1'b0; pri_d = 8'd0;
        vpulse();
        hpulse(2);
        push("pri_resync", mk(0, 0, 0)); chk1();
        push("pri_line99", mk(0, 0, 47));
        hpulse(99); chk1();
        push("pri_int_100", mk(1, 1, 48));
        hpulse(1); chk1();
        push("pri_ack_keeps_cnt", mk(0, 1, 48));
        ack(); chk1();
        push("pri_no_more_int", mk(0, 1, 46));
        hpulse(50); chk1();

        // Second instance: LINE_DIV=13, CNT_W=4, VS_DELAY=3.
        rst2_n = 1'b1;
        tick();
        push("d2_line12", mk(0, 0, 12));
        hpulse(12); chk2();
        push("d2_int_13", mk(1, 0, 0));
        hpulse(1); chk2();
        ack();
        push("d2_int_26", mk(1, 0, 0));
        hpulse(13); chk2();
        ack();
        hpulse(8);
        vpulse();
        push("d2_vs_line2", mk(0, 0, 10));
        hpulse(2); chk2();
        push("d2_vs_resync3", mk(1, 0, 0));
        hpulse(1); chk2();
        ack();
        hpulse(13);
        push("d2_mid_count", mk(1, 0, 3));
        hpulse(3); chk2();
        rst2_n = 1'b0;
        #1;
        push("d2_async_reset", mk(0, 0, 0)); chk2();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ga_raster_irq.md
GA_RASTER_IRQ -- requirements
Module: ga_raster_irq

Interface
REQ-001 SHALL have parameter LINE_DIV, default 52: the number of HSYNC-end events per periodic interrupt; legal range 2..2**CNT_W.
REQ-002 SHALL have parameter CNT_W, default 6: width of the line-divider counter; its MSB is the ack/vsync guard bit.
REQ-003 SHALL have parameter VS_DELAY, default 2: the number of HSYNC-end events after VSYNC rise before counter resync; legal range 1..8.
REQ-004 SHALL have parameter PRI_W, default 8: width of the programmable raster line compare and the raster line counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  system clock, all state on its rising edge.
REQ-006 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-007 SHALL have port CE  in  1  sample strobe; HSYNC_IN/VSYNC_IN are evaluated only on CE=1 cycles.
REQ-008 SHALL have port HSYNC_IN  in  1  CRTC horizontal sync.
REQ-009 SHALL have port VSYNC_IN  in  1  CRTC vertical sync.
REQ-010 SHALL have port INTACK  in  1  Z80 interrupt-acknowledge pulse, one CLK wide, not CE-qualified.
REQ-011 SHALL have port WE  in  1  gate-array register write strobe, not CE-qualified.
REQ-012 SHALL have port D  in  8  gate-array write data.
REQ-013 SHALL have port PRI_WE  in  1  raster-compare register write strobe.
REQ-014 SHALL have port PRI_D  in  PRI_W  raster-compare write data.
REQ-015 SHALL have port INT  out  1  registered interrupt request.
REQ-016 SHALL have port INT_SRC  out  1  source of the last INT assertion: 0 = divider, 1 = raster compare.
REQ-017 SHALL have port LINE_CNT  out  CNT_W  current divider counter value, for debug.

Function
REQ-018 SHALL register HSYNC_IN and VSYNC_IN on each CE cycle; an H-event is a sampled 1->0 on HSYNC and a V-event is a sampled 0->1 on VSYNC.
REQ-019 On each H-event the divider counter SHALL increment; if its pre-increment value equals LINE_DIV-1, the counter SHALL become 0, and INT:=1 and INT_SRC:=0 unless PRI mode is active.
REQ-020 A V-event SHALL load a delay counter with VS_DELAY.
REQ-021 Each subsequent H-event SHALL decrement the delay counter.
REQ-022 On the H-event where the delay counter reaches 0, the divider counter SHALL become 0, and INT:=1 and INT_SRC:=0 if the pre-event counter MSB was 1 and PRI mode is inactive.
REQ-023 The REQ-022 resync SHALL override REQ-019 on the same event.
REQ-024 A V-event coinciding with an H-event SHALL reload the delay counter to VS_DELAY; that H-event SHALL NOT count as a delay step.
REQ-025 The raster line counter (PRI_W bits, saturating at all-ones) SHALL be cleared at the REQ-022 resync point and SHALL increment on every other H-event.
REQ-026 PRI mode SHALL be active while the PRI register is nonzero.
REQ-027 In PRI mode, on an H-event that makes the raster line counter equal the PRI register, INT:=1 and INT_SRC:=1.
REQ-028 In PRI mode, divider-sourced INT assertions SHALL be suppressed; the divider counter SHALL keep counting.
REQ-029 PRI_WE SHALL load the PRI register from PRI_D in the same cycle; the new value SHALL take effect for compares from the next H-event.
REQ-030 INTACK SHALL clear INT.
REQ-031 INTACK SHALL clear the divider counter MSB when INT_SRC=0; when INT_SRC=1, the counter SHALL be left unchanged.
REQ-032 WE with D[7:6]=2'b10 and D[4]=1 SHALL clear INT and the divider counter; the delay and raster counters SHALL be unaffected.
REQ-033 Same-cycle priority SHALL be, lowest to highest: H-event updates, then INTACK, then WE clear; the later source in this order overrides earlier ones on overlapping bits.
REQ-034 INT asserted by an H-event in the same cycle as INTACK SHALL end up 0.
REQ-035 All arithmetic SHALL be unsigned modulo the stated widths; the divider counter SHALL never exceed LINE_DIV-1.

Reset
REQ-036 While RESET_N=0, INT, INT_SRC, LINE_CNT, the delay counter, the raster counter, the PRI register and the sync samples SHALL all be 0, asynchronously.
REQ-037 The first CE after RESET_N deasserts SHALL only capture samples; it SHALL generate no H-event or V-event.
REQ-038 Reset asserted mid-frame or with INT=1 SHALL drop INT immediately.

Verification
REQ-039 Defaults, 52 H-events with no VSYNC -> INT rises on the 52nd event, LINE_CNT=0, INT_SRC=0; INTACK one cycle later -> INT=0.
REQ-040 Defaults, INTACK when LINE_CNT=40 -> LINE_CNT=8; the next INT arrives after 44 further H-events.
REQ-041 V-event with LINE_CNT=40 -> INT after the 2nd H-event with LINE_CNT=0; repeating with LINE_CNT=10 -> no INT, LINE_CNT=0.
REQ-042 PRI_D=100 written, then a V-event -> exactly one INT with INT_SRC=1, on the 100th H-event after the resync point; no divider INTs occur within the frame.
REQ-043 WE D=8'h90 in the same cycle as INTACK and a terminal H-event -> INT=0, LINE_CNT=0.
REQ-044 LINE_DIV=13, CNT_W=4, VS_DELAY=3 -> INT every 13 H-events; the resync point falls on the 3rd H-event after VSYNC; RESET_N pulse mid-count -> all outputs 0 within the same cycle.
